// File: rtl/totd_40mhz_ctrl.sv
// ToTd 40 MHz compatibility sequencer: ENABLE40 phase, shadowed trigger
// config with phase-aligned apply and flush, trigger holdoff and counting.
module totd_40mhz_ctrl #(
  parameter int ADC_WIDTH = 12,
  parameter int OCC_BITS  = 7,
  parameter int FLUSH_CYC = 366,
  parameter int HOLD_BITS = 16
) (
  input  logic                 CLK120,
  input  logic                 RESET,
  input  logic                 RUN,
  input  logic                 CFG_WR,
  input  logic [ADC_WIDTH-1:0] CFG_THRES0,
  input  logic [ADC_WIDTH-1:0] CFG_THRES1,
  input  logic [ADC_WIDTH-1:0] CFG_THRES2,
  input  logic [2:0]           CFG_TRIG_ENABLE,
  input  logic [1:0]           CFG_MULTIPLICITY,
  input  logic [OCC_BITS-1:0]  CFG_OCCUPANCY,
  input  logic [HOLD_BITS-1:0] HOLDOFF,
  input  logic                 CNT_CLR,
  input  logic                 TRIG_IN,
  output logic [1:0]           ENABLE40,
  output logic [ADC_WIDTH-1:0] THRES0,
  output logic [ADC_WIDTH-1:0] THRES1,
  output logic [ADC_WIDTH-1:0] THRES2,
  output logic [2:0]           TRIG_ENABLE,
  output logic [1:0]           MULTIPLICITY,
  output logic [OCC_BITS-1:0]  OCCUPANCY,
  output logic                 DP_RESET,
  output logic                 TRIG_OUT,
  output logic [15:0]          TRIG_COUNT,
  output logic                 CFG_PENDING,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    S_DIS  = 2'd0,
    S_ARM  = 2'd1,
    S_HOLD = 2'd2,
    S_RCFG = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADC_WIDTH-1:0] t0;
    logic [ADC_WIDTH-1:0] t1;
    logic [ADC_WIDTH-1:0] t2;
    logic [2:0]           en;
    logic [1:0]           mult;
    logic [OCC_BITS-1:0]  occ;
  } cfg_t;

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  localparam cfg_t CFG_RST = '{
    t0:   {ADC_WIDTH{1'b1}},
    t1:   {ADC_WIDTH{1'b1}},
    t2:   {ADC_WIDTH{1'b1}},
    en:   3'b000,
    mult: 2'b00,
    occ:  {OCC_BITS{1'b1}}
  };

  logic [1:0]           phase_q;
  state_e               state_q;
  state_e               state_d;
  cfg_t                 shadow_q;
  cfg_t                 active_q;
  cfg_t                 cfg_in;
  logic                 pend_q;
  logic [FW-1:0]        flush_q;
  logic [HOLD_BITS-1:0] hold_q;
  logic                 trig_q;
  logic [15:0]          cnt_q;
  logic                 dprst_q;
  logic                 accept;
  logic                 apply;

  assign cfg_in = '{
    t0:   CFG_THRES0,
    t1:   CFG_THRES1,
    t2:   CFG_THRES2,
    en:   CFG_TRIG_ENABLE,
    mult: CFG_MULTIPLICITY,
    occ:  CFG_OCCUPANCY
  };

  // A trigger in ARMED pre-empts a phase-2 apply; the apply retries later.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    apply   = 1'b0;
    if (!RUN) begin
      state_d = S_DIS;
    end else begin
      unique case (state_q)
        S_DIS: begin
          state_d = S_RCFG;
          apply   = 1'b1;
        end
        S_ARM: begin
          if (TRIG_IN) begin
            accept = 1'b1;
            if (HOLDOFF != '0) state_d = S_HOLD;
          end else if (pend_q && phase_q == 2'd2) begin
            state_d = S_RCFG;
            apply   = 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_q <= HOLD_BITS'(1)) state_d = S_ARM;
        end
        S_RCFG: begin
          if (flush_q == '0) state_d = S_ARM;
        end
        default: state_d = S_DIS;
      endcase
    end
  end

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      phase_q  <= 2'd0;
      state_q  <= S_DIS;
      shadow_q <= CFG_RST;
      active_q <= CFG_RST;
      pend_q   <= 1'b0;
      flush_q  <= '0;
      hold_q   <= '0;
      trig_q   <= 1'b0;
      cnt_q    <= 16'd0;
      dprst_q  <= 1'b1;
    end else begin
      phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      state_q <= state_d;
      dprst_q <= (state_d == S_DIS) || (state_d == S_RCFG);
      trig_q  <= accept;

      if (CFG_WR) shadow_q <= cfg_in;
      if (apply) active_q <= shadow_q;

      if (CFG_WR)     pend_q <= 1'b1;
      else if (apply) pend_q <= 1'b0;

      if (apply)
        flush_q <= FLUSH_LAST;
      else if (state_q == S_RCFG && flush_q != '0)
        flush_q <= flush_q - FW'(1);

      if (accept)
        hold_q <= HOLDOFF;
      else if (state_q == S_HOLD && hold_q != '0)
        hold_q <= hold_q - HOLD_BITS'(1);

      if (CNT_CLR)
        cnt_q <= accept ? 16'd1 : 16'd0;
      else if (accept && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ENABLE40     = phase_q;
  assign THRES0       = active_q.t0;
  assign THRES1       = active_q.t1;
  assign THRES2       = active_q.t2;
  assign TRIG_ENABLE  = active_q.en;
  assign MULTIPLICITY = active_q.mult;
  assign OCCUPANCY    = active_q.occ;
  assign DP_RESET     = dprst_q;
  assign TRIG_OUT     = trig_q;
  assign TRIG_COUNT   = cnt_q;
  assign CFG_PENDING  = pend_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_totd_40mhz_ctrl.sv
// Bench for totd_40mhz_ctrl: accepted triggers are scoreboarded against
// a count model; config apply, flush, holdoff and reset are checked inline.
module tb_totd_40mhz_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        cfg_wr;
  logic [11:0] c_t0, c_t1, c_t2;
  logic [2:0]  c_en;
  logic [1:0]  c_mult;
  logic [6:0]  c_occ;
  logic [15:0] holdoff;
  logic        cnt_clr;
  logic        trig_in;
  logic [1:0]  en40;
  logic [11:0] t0, t1, t2;
  logic [2:0]  ten;
  logic [1:0]  mult;
  logic [6:0]  occ;
  logic        dp_rst;
  logic        trig_out;
  logic [15:0] tcnt;
  logic        pend;
  logic [1:0]  st;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cnt_m = 16'd0;
  logic [15:0] exp_q[$];
  int          n;

  totd_40mhz_ctrl dut (
    .CLK120(clk), .RESET(rst), .RUN(run), .CFG_WR(cfg_wr),
    .CFG_THRES0(c_t0), .CFG_THRES1(c_t1), .CFG_THRES2(c_t2),
    .CFG_TRIG_ENABLE(c_en), .CFG_MULTIPLICITY(c_mult),
    .CFG_OCCUPANCY(c_occ), .HOLDOFF(holdoff), .CNT_CLR(cnt_clr),
    .TRIG_IN(trig_in), .ENABLE40(en40),
    .THRES0(t0), .THRES1(t1), .THRES2(t2),
    .TRIG_ENABLE(ten), .MULTIPLICITY(mult), .OCCUPANCY(occ),
    .DP_RESET(dp_rst), .TRIG_OUT(trig_out), .TRIG_COUNT(tcnt),
    .CFG_PENDING(pend), .STATE(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_acc();
    if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    exp_q.push_back(cnt_m);
  endfunction

  task automatic wait_state(input logic [1:0] s, output int cyc);
    cyc = 0;
    while (st == s && cyc < 2000) begin
      cyc++;
      tick();
    end
  endtask

  task automatic sync_ph0();
    for (int k = 0; k < 3 && en40 != 2'd0; k++) tick();
  endtask

  always @(negedge clk) begin
    if (trig_out) begin
      if (exp_q.size() == 0) chk("trig_unexpected", 1, 0);
      else chk("trig_count", tcnt, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; cfg_wr = 1'b0;
    c_t0 = '0; c_t1 = '0; c_t2 = '0; c_en = '0; c_mult = '0; c_occ = '0;
    holdoff = '0; cnt_clr = 1'b0; trig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en40", en40, 0);
    chk("rst_state", st, 0);
    chk("rst_dprst", dp_rst, 1);
    chk("rst_trig", trig_out, 0);
    chk("rst_cnt", tcnt, 0);
    chk("rst_pend", pend, 0);
    chk("rst_thres", {t0, t1, t2}, 36'hFFF_FFF_FFF);
    chk("rst_bank", {ten, mult, occ}, {3'b000, 2'b00, 7'h7F});

    rst = 1'b0;
    tick(); chk("ph_1", en40, 1);
    tick(); chk("ph_2", en40, 2);
    tick(); chk("ph_0", en40, 0);
    chk("dis_dprst", dp_rst, 1);

    // 1: first RUN goes through a full flush with reset-value bank
    run = 1'b1;
    tick(); chk("run_rcfg", st, 3);
    wait_state(2'd3, n);
    chk("flush1_len", n, 366);
    chk("armed1", {st, dp_rst}, {2'd1, 1'b0});
    chk("bank1", {t0, occ}, {12'hFFF, 7'h7F});

    // 2: write at phase 0, apply after the next phase 2
    sync_ph0();
    c_t0 = 12'h050; c_t1 = 12'h111; c_t2 = 12'h222;
    c_en = 3'b101; c_mult = 2'd2; c_occ = 7'd13; cfg_wr = 1'b1;
    tick(); cfg_wr = 1'b0;
    chk("wr_pend", pend, 1);
    chk("wr_noapply", {st, t0}, {2'd1, 12'hFFF});
    tick(); chk("wr_ph2", {en40, st}, {2'd2, 2'd1});
    tick();
    chk("apply_st", {st, en40, dp_rst, pend}, {2'd3, 2'd0, 1'b1, 1'b0});
    chk("apply_thr", {t0, t1, t2}, 36'h050_111_222);
    chk("apply_bank", {ten, mult, occ}, {3'b101, 2'd2, 7'd13});
    wait_state(2'd3, n);
    chk("flush2_len", n, 366);
    chk("armed2", {st, dp_rst}, {2'd1, 1'b0});

    // 3: holdoff of 10 dead cycles
    holdoff = 16'd10; trig_in = 1'b1; push_acc();
    tick(); trig_in = 1'b0;
    chk("hold_enter", st, 2);
    repeat (4) tick();
    trig_in = 1'b1;
    tick(); trig_in = 1'b0;
    chk("hold_stay", st, 2);
    tick(); chk("hold_ignored", trig_out, 0);
    repeat (4) tick();
    chk("hold_exit", st, 1);
    holdoff = 16'd0; trig_in = 1'b1; push_acc();
    tick(); trig_in = 1'b0;
    chk("hold_cnt", tcnt, 2);

    // 4: zero holdoff, back-to-back triggers
    for (int i = 0; i < 5; i++) begin
      trig_in = 1'b1; push_acc(); tick();
    end
    trig_in = 1'b0;
    tick();
    chk("b2b_cnt", {st, tcnt}, {2'd1, 16'd7});

    // 5: saturation, then clear racing a trigger
    for (int i = 0; i < 65530; i++) begin
      trig_in = 1'b1; push_acc(); tick();
    end
    trig_in = 1'b0;
    tick(); chk("sat_cnt", tcnt, 16'hFFFF);
    cnt_clr = 1'b1; trig_in = 1'b1; cnt_m = 16'd0; push_acc();
    tick(); trig_in = 1'b0;
    chk("clr_trig", tcnt, 1);
    tick(); cnt_clr = 1'b0; cnt_m = 16'd0;
    chk("clr_only", tcnt, 0);

    // 6: trigger on the phase-2 apply cycle defers the apply
    sync_ph0();
    c_t0 = 12'h0AA; cfg_wr = 1'b1;
    tick(); cfg_wr = 1'b0;
    tick(); chk("def_ph2", {en40, pend}, {2'd2, 1'b1});
    trig_in = 1'b1; push_acc();
    tick(); trig_in = 1'b0;
    chk("def_keep", {st, t0, pend}, {2'd1, 12'h050, 1'b1});
    repeat (2) tick();
    chk("def_ph2b", {en40, st}, {2'd2, 2'd1});
    tick(); chk("def_apply", {st, t0, en40}, {2'd3, 12'h0AA, 2'd0});
    repeat (5) tick();
    run = 1'b0;
    tick(); chk("drop_run", {st, dp_rst}, {2'd0, 1'b1});
    repeat (3) tick();
    chk("dis_hold", {dp_rst, t0}, {1'b1, 12'h0AA});
    run = 1'b1;
    tick(); wait_state(2'd3, n);
    chk("flush3_len", n, 366);

    // async reset in the middle of a holdoff window
    holdoff = 16'd50; trig_in = 1'b1; push_acc();
    tick(); trig_in = 1'b0;
    chk("hold50", st, 2);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk("ar_ctl", {en40, st, dp_rst, trig_out, pend},
        {2'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    chk("ar_cnt", tcnt, 0);
    chk("ar_bank", {t0, ten, occ}, {12'hFFF, 3'b000, 7'h7F});
    cnt_m = 16'd0;
    @(posedge clk); #1 rst = 1'b0;
    tick(); chk("ar_shadow_lost", {st, t0, occ}, {2'd3, 12'hFFF, 7'h7F});
    run = 1'b0;
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
